// File: rtl/avg_frame_feeder.sv
// avg_frame_feeder: buffers a free-running sample stream in a FIFO and feeds
// whole frames to the averager (start, then contiguous first..last beats),
// waiting for the averager's done before the next frame.
// Optional done-watchdog: define AVG_FEED_WDOG_EN.
module avg_frame_feeder #(
  parameter int NOF_BITS    = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int LEN_BITS    = 8,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [LEN_BITS-1:0]           frame_len,
  input  logic                          s_valid,
  input  logic [NOF_BITS-1:0]           s_data,
  output logic                          s_ready,
  output logic                          avg_start,
  output logic                          avg_first,
  output logic                          avg_last,
  output logic [NOF_BITS-1:0]           avg_data,
  input  logic                          avg_busy,
  input  logic                          avg_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   frames_sent,
  output logic                          err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (LW > LEN_BITS) ? LW : LEN_BITS;
  localparam int WW = $clog2(WDOG_CYCLES) + 1;

  if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (WDOG_CYCLES < 1) begin : g_bad_wdog
    $error("WDOG_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_STREAM, S_WAIT_DONE} state_t;

  state_t                state_q, state_d;
  logic [LEN_BITS-1:0]   len_q, len_d;
  logic [LEN_BITS-1:0]   beat_q, beat_d;
  logic [15:0]           frames_q, frames_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  start_q, start_d;
  logic                  first_q, first_d;
  logic                  last_q, last_d;
  logic [NOF_BITS-1:0]   data_q, data_d;
  logic [NOF_BITS-1:0]   mem_q [FIFO_DEPTH];

  logic                  full;
  logic                  push;
  logic                  pop;
  logic [LEN_BITS-1:0]   len_eff;

`ifdef AVG_FEED_WDOG_EN
  logic [WW-1:0]         wd_q, wd_d;
  logic                  err_q, err_d;
`endif

  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign push    = s_valid && !full;
  assign len_eff = (frame_len == '0) ? LEN_BITS'(1) : frame_len;

  // Next-state, counters and FIFO bookkeeping; outputs are derived from the
  // next state so each registered output lines up with the state it belongs to.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    beat_d   = beat_q;
    frames_d = frames_q;
`ifdef AVG_FEED_WDOG_EN
    wd_d     = wd_q;
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (enable && !avg_busy && (CW'(level_q) >= CW'(len_eff))) begin
          state_d = S_ARM;
          len_d   = len_eff;
        end
      end
      S_ARM: begin
        state_d = S_STREAM;
        beat_d  = '0;
      end
      S_STREAM: begin
        if (beat_q == len_q - LEN_BITS'(1)) begin
          state_d = S_WAIT_DONE;
`ifdef AVG_FEED_WDOG_EN
          wd_d    = '0;
`endif
        end else begin
          beat_d = beat_q + LEN_BITS'(1);
        end
      end
      S_WAIT_DONE: begin
        if (avg_done) begin
          frames_d = frames_q + 16'd1;
          state_d  = S_IDLE;
        end
`ifdef AVG_FEED_WDOG_EN
        else if (wd_q == WW'(WDOG_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WW'(1);
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    pop      = (state_d == S_STREAM);
    start_d  = (state_d == S_ARM);
    first_d  = pop && (beat_d == '0);
    last_d   = pop && (beat_d == len_d - LEN_BITS'(1));
    data_d   = pop ? mem_q[rd_ptr_q] : '0;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  // Control and output registers; reset flushes the FIFO and abandons any frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      beat_q   <= '0;
      frames_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      start_q  <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      frames_q <= frames_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      start_q  <= start_d;
      first_q  <= first_d;
      last_q   <= last_d;
      data_q   <= data_d;
    end
  end

  // Sample storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

`ifdef AVG_FEED_WDOG_EN
  // Done-watchdog counter and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign s_ready     = !full;
  assign avg_start   = start_q;
  assign avg_first   = first_q;
  assign avg_last    = last_q;
  assign avg_data    = data_q;
  assign fifo_level  = level_q;
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_avg_frame_feeder.sv
// Self-checking bench for avg_frame_feeder: directed scenarios plus random
// traffic, compared every cycle against a queue-based frame model.
module tb_avg_frame_feeder;

  localparam int DEPTH = 16;
  localparam int WDOG  = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  frame_len;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        avg_start, avg_first, avg_last;
  logic [31:0] avg_data;
  logic        avg_busy, avg_done;
  logic [4:0]  fifo_level;
  logic [15:0] frames_sent;
  logic        err;

  avg_frame_feeder #(.NOF_BITS(32), .FIFO_DEPTH(DEPTH), .LEN_BITS(8), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_len(frame_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .avg_start(avg_start), .avg_first(avg_first), .avg_last(avg_last), .avg_data(avg_data),
    .avg_busy(avg_busy), .avg_done(avg_done), .fifo_level(fifo_level),
    .frames_sent(frames_sent), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Model: samples held, frame progress (0 idle, 1 armed, 2 streaming, 3 awaiting done)
  logic [31:0] q[$];
  int          m_phase, m_len, m_beat, m_wd;
  int          m_frames;
  logic        m_err;
  logic        exp_last;
  bit          accepted;

  // Stimulus controls
  logic [31:0] pend[$];
  bit          rand_mode = 0;
  bit          auto_done = 1;
  int          done_dly  = 2;
  int          done_timer = 0;

  task automatic model_reset();
    q.delete();
    m_phase = 0; m_len = 0; m_beat = 0; m_wd = 0; m_frames = 0; m_err = 1'b0;
    exp_last = 1'b0;
  endtask

  // One clock: capture inputs, advance model, compare every output after the edge.
  task automatic step();
    bit   p_en, p_busy, p_sv, p_done;
    int   p_fl;
    logic [31:0] p_sd, e_data;
    p_en = enable; p_busy = avg_busy; p_sv = s_valid; p_done = avg_done;
    p_fl = (frame_len == 0) ? 1 : int'(frame_len);
    p_sd = s_data;
    accepted = p_sv && (q.size() < DEPTH);
    @(posedge clk); #1;
    case (m_phase)
      0: if (p_en && !p_busy && q.size() >= p_fl) begin m_phase = 1; m_len = p_fl; end
      1: begin m_phase = 2; m_beat = 0; end
      2: if (m_beat == m_len - 1) begin m_phase = 3; m_wd = 0; end else m_beat++;
      default: begin
        if (p_done) begin m_frames = (m_frames + 1) & 16'hFFFF; m_phase = 0; end
`ifdef AVG_FEED_WDOG_EN
        else if (m_wd == WDOG - 1) begin m_err = 1'b1; m_phase = 0; end
        else m_wd++;
`endif
      end
    endcase
    e_data = '0;
    if (m_phase == 2) e_data = q.pop_front();
    if (accepted) q.push_back(p_sd);
    exp_last = (m_phase == 2) && (m_beat == m_len - 1);
    check("start", 32'(avg_start), 32'(m_phase == 1));
    check("first", 32'(avg_first), 32'(m_phase == 2 && m_beat == 0));
    check("last",  32'(avg_last),  32'(exp_last));
    check("data",  avg_data, e_data);
    check("level", 32'(fifo_level), 32'(q.size()));
    check("ready", 32'(s_ready), 32'(q.size() < DEPTH));
    check("frames", 32'(frames_sent), 32'(m_frames));
    check("err", 32'(err), 32'(m_err));
  endtask

  task automatic cycle();
    if (rand_mode) begin
      s_valid  = ($urandom_range(0, 2) != 0);
      s_data   = $urandom;
      avg_busy = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if ($urandom_range(0, 29) == 0) frame_len = 8'($urandom_range(0, 7));
    end else begin
      s_valid = (pend.size() > 0);
      s_data  = (pend.size() > 0) ? pend[0] : 32'hDEAD_BEEF;
    end
    avg_done = (done_timer == 1) || (rand_mode && $urandom_range(0, 39) == 0);
    if (done_timer > 0) done_timer--;
    step();
    if (!rand_mode && accepted && pend.size() > 0) void'(pend.pop_front());
    if (exp_last && auto_done) begin
      done_timer = done_dly;
      if (rand_mode) done_dly = $urandom_range(1, 6);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_ready", 32'(s_ready), 32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_avg", {29'd0, avg_start, avg_first, avg_last}, 32'd0);
    check("rst_data", avg_data, 32'd0);
    check("rst_frames", 32'(frames_sent), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    model_reset();
    pend.delete();
    done_timer = 0;
    avg_done = 1'b0;
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; frame_len = 8'd4; s_valid = 1'b0; s_data = '0;
    avg_busy = 1'b0; avg_done = 1'b0;
    #2;
    apply_reset();

    // T2: four-sample frame with known data
    frame_len = 8'd4; enable = 1'b0; done_dly = 3;
    pend = '{32'd10, 32'd20, 32'd30, 32'd40};
    run(5);
    enable = 1'b1;
    run(12);
    check("t2_frames", 32'(frames_sent), 32'd1);
    check("t2_level", 32'(fifo_level), 32'd0);

    // T3: frame_len 0 behaves as a single-beat frame
    frame_len = 8'd0; pend = '{32'd7};
    run(8);
    check("t3_frames", 32'(frames_sent), 32'd2);

    // T4: fill past full with framing disabled, then drain
    enable = 1'b0; frame_len = 8'd4;
    for (int i = 0; i < 17; i++) pend.push_back(32'h100 + i);
    run(20);
    check("t4_ready", 32'(s_ready), 32'd0);
    check("t4_level", 32'(fifo_level), 32'd16);
    enable = 1'b1;
    run(40);
    check("t4_ready_back", 32'(s_ready), 32'd1);

    // T5: back-to-back frames of 3 with done two cycles after each last
    apply_reset();
    frame_len = 8'd3; done_dly = 2;
    for (int i = 0; i < 6; i++) pend.push_back(32'h500 + i);
    run(20);
    check("t5_frames", 32'(frames_sent), 32'd2);

    // T1: reset in the middle of a frame
    frame_len = 8'd8;
    for (int i = 0; i < 8; i++) pend.push_back(32'h900 + i);
    begin
      int guard = 0;
      while (!(m_phase == 2 && m_beat == 3) && guard < 40) begin cycle(); guard++; end
      check("t1_reached_mid", 32'(guard < 40), 32'd1);
    end
    apply_reset();

    // T6: averager never answers done
    auto_done = 0; frame_len = 8'd2; enable = 1'b1;
    pend = '{32'hA1, 32'hA2};
    run(WDOG + 16);
`ifdef AVG_FEED_WDOG_EN
    check("t6_err", 32'(err), 32'd1);
`else
    check("t6_err", 32'(err), 32'd0);
`endif
    check("t6_frames", 32'(frames_sent), 32'd0);
    apply_reset();

    // Random traffic
    auto_done = 1; rand_mode = 1; done_dly = 2; enable = 1'b1; frame_len = 8'd3;
    run(3000);
    rand_mode = 0;
    apply_reset();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
